counter_access_arbiter: RTL
===========================

// Module: counter_access_arbiter
// PURPOSE
//  Clocked controller that shares one 8-bit self-timed up-counter among NREQ requesters.
//  Round-robin arbitrates increment/clear commands and drives the counter's enable/clr inputs.
//  Sequences each command over a four-phase ctr_req/ctr_ack handshake with the counter's
//  handshake wrapper, then returns the resulting count to the granted requester.
//  Sits between synchronous client logic and the asynchronous counter domain.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  WIDTH       8   counter width
//  SYNC_STAGES 2   flop stages on ctr_ack and ctr_out (>=2)
//  TIMEOUT     15  max cycles waiting per handshake edge before error (4-bit timer)
// PORTS
//  clk        in   1          system clock, rising edge
//  reset_n    in   1          asynchronous active-low reset
//  req        in   NREQ       per-requester command request, level
//  op         in   NREQ       per-requester opcode: 0 = increment, 1 = clear
//  gnt        out  NREQ       one-hot grant, held for whole transaction
//  done       out  NREQ       one-cycle completion pulse to granted requester
//  cnt_val    out  WIDTH      count after last completed command
//  ctr_enable out  1          to counter enable
//  ctr_clr    out  1          to counter clr
//  ctr_req    out  1          four-phase request to counter wrapper
//  ctr_ack    in   1          four-phase ack from counter wrapper (async, synchronised)
//  ctr_out    in   WIDTH      counter output (async, synchronised)
//  err        out  1          sticky: handshake timeout or count mismatch
//  err_clr    in   1          synchronous clear of err, returns FSM to IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0, cnt_val=0, timer=0. Async assert; reset
//   mid-transaction drops ctr_req/enable/clr immediately, no done issued.
//  FSM: IDLE -> SETUP -> REQ -> REL -> SAMPLE -> DONE -> IDLE; any -> ERR.
//  IDLE: if any req, grant first asserted index at/after rr pointer; latch op; gnt set next cycle.
//  SETUP (1 cycle): ctr_enable=~op_l, ctr_clr=op_l; ctr_req low (data setup before request).
//  REQ: ctr_req=1; exit when synchronised ack==1.
//  REL: ctr_req=0, enable/clr stay stable; exit when synchronised ack==0.
//  SAMPLE: wait until synchronised ctr_out equal on 2 consecutive cycles; compare with
//   expected (clear: 0; incr: cnt_val+1 mod 2^WIDTH, 0xFF wraps to 0x00).
//  DONE (1 cycle): cnt_val<=sampled; done[grantee]=1; enable/clr/gnt drop; rr=grantee+1 mod NREQ.
//  Mismatch in SAMPLE: cnt_val<=sampled, err=1, done still pulses, then IDLE.
//  Timeout: timer resets on entry to REQ and REL; TIMEOUT cycles without exit -> ERR.
//  ERR: ctr_req/enable/clr=0, gnt=0, no done, err=1; only err_clr (or reset) -> IDLE.
//   err_clr in any other state clears err only.
//  Latency, no stalls: grant 1 cycle after req; done = 4 + 2*SYNC_STAGES + ack delays.
//  req dropped after grant: transaction still completes, done pulses.
//  New grants only from IDLE; one outstanding command; requests never queued beyond req level.
//  ctr_enable and ctr_clr never both 1; ctr_enable/ctr_clr change only while ctr_req=0 and ack=0.
// TESTING
//  1 reset, req[0]=1 op=0, wrapper acks in 3 cycles, out 0->1 -> gnt=0001, done[0] once, cnt_val=1.
//  2 req=1111 all op=0 held -> grants 0,1,2,3,0 in order; cnt_val 1,2,3,4,5; gnt always one-hot.
//  3 cnt 0xFF, incr -> ctr_out 0x00 accepted, cnt_val=0x00, err=0; then op=1 on cnt 5 -> cnt_val=0.
//  4 ctr_ack stuck 0 -> err after TIMEOUT cycles in REQ, ctr_req=0, no done; err_clr -> IDLE, next req ok.
//  5 incr but ctr_out settles at value+2 -> done pulses, cnt_val=value+2, err=1 sticky.
//  6 reset_n low while in REL -> same-cycle ctr_req/enable/gnt=0; after release FSM IDLE, rr=0.

Source files
------------

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter that shares one self-timed up-counter among NREQ clients.
// Each command runs a four-phase ctr_req/ctr_ack handshake, then checks and reports the count.
module counter_access_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  op,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [WIDTH-1:0] cnt_val,
  output logic             ctr_enable,
  output logic             ctr_clr,
  output logic             ctr_req,
  input  logic             ctr_ack,
  input  logic [WIDTH-1:0] ctr_out,
  output logic             err,
  input  logic             err_clr
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_REL,
    S_SAMPLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;

  logic [IDXW-1:0]        rr_ptr;
  logic [IDXW-1:0]        gnt_idx;
  logic [IDXW-1:0]        pick_idx;
  logic [IDXW-1:0]        cand;
  logic                   pick_valid;
  logic                   op_l;
  logic [3:0]             timer;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [WIDTH-1:0]       out_sync [SYNC_STAGES];
  logic [WIDTH-1:0]       out_prev;
  logic                   ack_s;
  logic [WIDTH-1:0]       out_s;
  logic [WIDTH-1:0]       exp_val;

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign out_s   = out_sync[SYNC_STAGES-1];
  assign exp_val = op_l ? '0 : cnt_val + WIDTH'(1);

  // Both ack and count cross from the counter's self-timed domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) out_sync[i] <= '0;
      out_prev <= '0;
    end else begin
      ack_sync    <= {ack_sync[SYNC_STAGES-2:0], ctr_ack};
      out_sync[0] <= ctr_out;
      for (int i = 1; i < SYNC_STAGES; i++) out_sync[i] <= out_sync[i-1];
      out_prev <= out_s;
    end
  end

  // Scan downward so the requester closest to rr_ptr is the last one written.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDXW'((int'(rr_ptr) + i) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      op_l       <= 1'b0;
      timer      <= '0;
      gnt        <= '0;
      done       <= '0;
      cnt_val    <= '0;
      ctr_enable <= 1'b0;
      ctr_clr    <= 1'b0;
      ctr_req    <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= '0;
      if (err_clr) err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt        <= NREQ'(1) << pick_idx;
            gnt_idx    <= pick_idx;
            op_l       <= op[pick_idx];
            ctr_enable <= ~op[pick_idx];
            ctr_clr    <= op[pick_idx];
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          ctr_req <= 1'b1;
          timer   <= '0;
          state   <= S_REQ;
        end
        S_REQ: begin
          if (ack_s) begin
            ctr_req <= 1'b0;
            timer   <= '0;
            state   <= S_REL;
          end else if (timer == TMO_LAST) begin
            ctr_req    <= 1'b0;
            ctr_enable <= 1'b0;
            ctr_clr    <= 1'b0;
            gnt        <= '0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        S_REL: begin
          if (!ack_s) begin
            state <= S_SAMPLE;
          end else if (timer == TMO_LAST) begin
            ctr_enable <= 1'b0;
            ctr_clr    <= 1'b0;
            gnt        <= '0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        // A count is trusted only once it reads the same on two cycles in a row.
        S_SAMPLE: begin
          if (out_s == out_prev) begin
            cnt_val    <= out_s;
            done       <= gnt;
            gnt        <= '0;
            ctr_enable <= 1'b0;
            ctr_clr    <= 1'b0;
            rr_ptr     <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
            if (out_s != exp_val) err <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          if (err_clr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
